// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding and default
// multiply/divide occupancy of EX.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN         = 1'b0,
    ST_MULDIV_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned MULDIV_CYCLES_DEF = 4;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds a source of the
// instruction in IF/ID. Register zero never creates a dependency.
module load_use_detect (
  input  logic       id_ex_mem_read_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  input  logic       if_id_uses_rt_i,
  output logic       hazard_o
);

  always_comb begin
    hazard_o = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
               ((id_ex_rt_i == if_id_rs_i) ||
                (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));
  end

endmodule : load_use_detect

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush control: load-use bubbles, multi-cycle mul/div holds,
// taken-branch flushes, plus a saturating count of stalled cycles.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             muldiv_start,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_events
);

  hz_state_e        state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] events_q, events_d;
  logic             load_use;

  load_use_detect u_load_use (
    .id_ex_mem_read_i (id_ex_mem_read),
    .id_ex_rt_i       (id_ex_rt),
    .if_id_rs_i       (if_id_rs),
    .if_id_rt_i       (if_id_rt),
    .if_id_uses_rt_i  (if_id_uses_rt),
    .hazard_o         (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      events_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      events_q   <= events_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (branch_taken) begin
      state_d    = ST_RUN;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (muldiv_start) begin
            state_d    = ST_MULDIV_WAIT;
            wait_cnt_d = 4'(MULDIV_CYCLES - 1);
          end
        end
        ST_MULDIV_WAIT: begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Reset overrides every input so the pipeline sees a clean run state.
  always_comb begin
    stall        = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      busy = (state_q == ST_MULDIV_WAIT);
      if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (state_q == ST_MULDIV_WAIT) begin
        stall = 1'b1;
      end else if (muldiv_start) begin
        stall = 1'b1;
      end else if (load_use) begin
        stall        = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
    pc_write = ~stall;
  end

  always_comb begin
    events_d = events_q;
    if (stall && !(&events_q)) events_d = events_q + 1'b1;
  end

  assign stall_events = events_q;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: a behavioural model pushes expected outputs per step into a
// scoreboard queue; they are popped and compared at the falling edge.
module tb_hazard_stall_ctrl;

  localparam int unsigned MC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        if_id_uses_rt, id_ex_mem_read, muldiv_start, branch_taken;
  logic        stall, pc_write, if_id_flush, id_ex_bubble, busy;
  logic [15:0] stall_events;
  logic        s_stall, s_pc_write, s_if_id_flush, s_id_ex_bubble, s_busy;
  logic [3:0]  s_stall_events;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .muldiv_start(muldiv_start), .branch_taken(branch_taken),
    .stall(stall), .pc_write(pc_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .busy(busy), .stall_events(stall_events)
  );

  hazard_stall_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .muldiv_start(muldiv_start), .branch_taken(branch_taken),
    .stall(s_stall), .pc_write(s_pc_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .busy(s_busy), .stall_events(s_stall_events)
  );

  typedef struct {
    logic        stall;
    logic        pc_write;
    logic        flush;
    logic        bubble;
    logic        busy;
    logic [15:0] ev;
    logic [3:0]  ev4;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: remaining mul/div wait cycles and stall counts.
  int unsigned m_rem = 0;
  int unsigned m_ev  = 0;
  int unsigned m_ev4 = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic md, input logic br, input logic mr,
                      input logic [4:0] exrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt);
    exp_t e;
    logic haz;
    reset = r; muldiv_start = md; branch_taken = br; id_ex_mem_read = mr;
    id_ex_rt = exrt; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
    haz = mr && (exrt != 5'd0) && (exrt == rs || (urt && exrt == rt));
    e.stall = 1'b0; e.flush = 1'b0; e.bubble = 1'b0; e.busy = 1'b0;
    if (!r) begin
      e.busy = (m_rem != 0);
      if (br) begin
        e.flush = 1'b1; e.bubble = 1'b1;
      end else if (m_rem != 0 || md) begin
        e.stall = 1'b1;
      end else if (haz) begin
        e.stall = 1'b1; e.bubble = 1'b1;
      end
    end
    e.pc_write = !e.stall;
    e.ev  = 16'(m_ev);
    e.ev4 = 4'(m_ev4);
    sb.push_back(e);

    @(negedge clk);
    e = sb.pop_front();
    chk("stall",        {15'd0, stall},        {15'd0, e.stall});
    chk("pc_write",     {15'd0, pc_write},     {15'd0, e.pc_write});
    chk("if_id_flush",  {15'd0, if_id_flush},  {15'd0, e.flush});
    chk("id_ex_bubble", {15'd0, id_ex_bubble}, {15'd0, e.bubble});
    chk("busy",         {15'd0, busy},         {15'd0, e.busy});
    chk("stall_events", stall_events,          e.ev);
    chk("stall_events_sat", {12'd0, s_stall_events}, {12'd0, e.ev4});

    @(posedge clk);
    if (r) begin
      m_rem = 0; m_ev = 0; m_ev4 = 0;
    end else begin
      if (e.stall) begin
        if (m_ev  < 65535) m_ev++;
        if (m_ev4 < 15)    m_ev4++;
      end
      if (br)              m_rem = 0;
      else if (m_rem != 0) m_rem--;
      else if (md)         m_rem = MC - 1;
    end
    #1;
  endtask

  initial begin
    // reset with hostile inputs
    step(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    step(1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // load-use via rs, then clear
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd7, 1);
    step(0, 0, 0, 0, 5'd5, 5'd5, 5'd7, 1);
    // load-use via rt only when rt is a source
    step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1);
    step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
    // register zero never hazards
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    // mul/div pulse, with a second start ignored during the wait
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // load-use and mul/div together: mul/div wins
    step(0, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // taken branch in the second wait cycle
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // branch beats load-use and mul/div in RUN
    step(0, 1, 1, 1, 5'd6, 5'd6, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // reset mid-wait
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // 20 stalled cycles: narrow counter saturates at 15
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MULDIV_CYCLES, default 4, sets the number of stall cycles a multiply/divide occupies EX (legal range 2..15).
REQ-002 Parameter CNT_W, default 16, sets the width of the stall-event counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_id_rs  input  5  rs field of the instruction held in IF/ID.
REQ-006 if_id_rt  input  5  rt field of the instruction held in IF/ID.
REQ-007 if_id_uses_rt  input  1  IF/ID instruction reads rt as a source.
REQ-008 id_ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-009 id_ex_rt  input  5  destination register of the load in ID/EX.
REQ-010 muldiv_start  input  1  instruction in ID/EX is a multi-cycle mul/div entering EX this cycle.
REQ-011 branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-012 stall  output  1  hold IF/ID contents (drives the IF/ID stall input).
REQ-013 pc_write  output  1  PC register load enable.
REQ-014 if_id_flush  output  1  IF/ID loads a NOP (zero instruction) next edge.
REQ-015 id_ex_bubble  output  1  ID/EX control fields forced to zero next edge.
REQ-016 busy  output  1  FSM is in MULDIV_WAIT.
REQ-017 stall_events  output  CNT_W  saturating count of cycles with stall=1.

Function
REQ-018 FSM SHALL have states RUN and MULDIV_WAIT plus a 4-bit down-counter wait_cnt.
REQ-019 Load-use hazard SHALL be: id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
REQ-020 In RUN with load-use hazard and no branch_taken: stall=1, pc_write=0, id_ex_bubble=1, if_id_flush=0, for exactly that cycle (combinational, same-cycle effect).
REQ-021 In RUN with muldiv_start and no branch_taken: next state MULDIV_WAIT, wait_cnt loaded with MULDIV_CYCLES-1; the current cycle SHALL assert stall=1, pc_write=0, id_ex_bubble=0.
REQ-022 In MULDIV_WAIT: stall=1, pc_write=0, id_ex_bubble=0, busy=1; wait_cnt decrements each cycle; at wait_cnt==1 next state is RUN.
REQ-023 Total stall for one mul/div SHALL be exactly MULDIV_CYCLES cycles, including the start cycle.
REQ-024 branch_taken SHALL have highest priority in any state: stall=0, pc_write=1, if_id_flush=1, id_ex_bubble=1, next state RUN, wait_cnt cleared.
REQ-025 In RUN with no hazard, no muldiv_start, no branch_taken: stall=0, pc_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-026 Load-use and muldiv_start in the same RUN cycle: mul/div path wins; id_ex_bubble=0.
REQ-027 muldiv_start while in MULDIV_WAIT SHALL be ignored.
REQ-028 pc_write SHALL equal ~stall in every cycle.
REQ-029 stall_events SHALL increment by 1 at each edge where stall=1 and hold at all-ones (no wrap).

Reset
REQ-030 While reset=1: state RUN, wait_cnt=0, stall_events=0; outputs stall=0, pc_write=1, if_id_flush=0, id_ex_bubble=0, busy=0 regardless of other inputs.
REQ-031 Reset asserted mid-MULDIV_WAIT SHALL abort the wait; first cycle after release is RUN.

Structure
REQ-032 State encoding and MULDIV_CYCLES default SHALL live in the shared pipeline package pipe_ctrl_pkg.
REQ-033 The block SHALL be flat; the load-use comparator MAY be a sub-module named load_use_detect.

Verification
REQ-034 lw $5 in ID/EX, add rs=$5 in IF/ID -> one cycle stall=1, pc_write=0, id_ex_bubble=1; next cycle stall=0.
REQ-035 lw $0 in ID/EX, IF/ID rs=$0 -> stall=0 (register zero never hazards).
REQ-036 muldiv_start pulse, MULDIV_CYCLES=4 -> stall=1 for exactly 4 cycles, busy=1 for 3; stall_events +4.
REQ-037 branch_taken in 2nd MULDIV_WAIT cycle -> stall=0, if_id_flush=1, id_ex_bubble=1 that cycle; RUN next.
REQ-038 reset in MULDIV_WAIT -> outputs at reset values; state RUN after release; stall_events=0.
REQ-039 CNT_W=4, 20 stall cycles -> stall_events saturates at 15.
